// File: rtl/mp_pkg.sv
// Shared types and defaults for the multi-precision arithmetic sequencer.
package mp_pkg;

    localparam int unsigned MP_NBYTES = 4;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        SHL = 2'd2,
        CMP = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        STEP = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/mp_seq.sv
// Multi-precision sequencer: steps the 8-bit ALU and Flags register one byte
// per cycle to run ADD/SUB/SHL/CMP on operands up to NBYTES bytes.
module mp_seq
    import mp_pkg::*;
#(
    parameter int unsigned NBYTES = MP_NBYTES,
    parameter int unsigned IW     = $clog2(NBYTES)
) (
    input  logic          Clk,
    input  logic          Res,
    input  logic          Start,
    input  logic [1:0]    Op,
    input  logic [IW:0]   Len,
    input  logic          Carry,
    input  logic          SCarry,
    input  logic          gtFlag,
    input  logic          ByteEq,
    output logic          Busy,
    output logic          Done,
    output logic          Err,
    output logic [IW-1:0] ByteIdx,
    output logic [1:0]    AluOp,
    output logic          CinOut,
    output logic          WrEn,
    output logic          FlagClr,
    output logic          CarryOut,
    output logic          GtOut,
    output logic          EqOut
);

    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic [IW:0]   len_q, len_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          eq_acc_q, eq_acc_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          wren_q, wren_d;
    logic          fclr_q, fclr_d;
    logic          cout_q, cout_d;
    logic          gt_q, gt_d;
    logic          eq_q, eq_d;
    logic          len_ok;
    logic          last_up;

    assign len_ok  = (Len != '0) && (Len <= (IW+1)'(NBYTES));
    assign last_up = ({1'b0, idx_q} == (len_q - (IW+1)'(1)));

    // Next-state, index walk and result-flag capture.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        len_d    = len_q;
        idx_d    = idx_q;
        eq_acc_d = eq_acc_q;
        err_d    = 1'b0;
        cout_d   = cout_q;
        gt_d     = gt_q;
        eq_d     = eq_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        wren_d   = 1'b0;
        fclr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (len_ok) begin
                        op_d    = op_t'(Op);
                        len_d   = Len;
                        cout_d  = 1'b0;
                        gt_d    = 1'b0;
                        eq_d    = 1'b0;
                        state_d = CLR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLR: begin
                // CMP walks from the most significant byte down.
                idx_d    = (op_q == CMP) ? IW'(len_q - (IW+1)'(1)) : '0;
                eq_acc_d = 1'b1;
                state_d  = STEP;
            end
            STEP: begin
                if (op_q == CMP) begin
                    if (!ByteEq) begin
                        eq_acc_d = 1'b0;
                        state_d  = FIN;
                    end else if (idx_q == '0) begin
                        state_d = FIN;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end else if (last_up) begin
                    state_d = FIN;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            FIN: begin
                // Flags now hold the outcome of the last byte step.
                cout_d  = (op_q == SHL) ? SCarry : ((op_q == CMP) ? 1'b0 : Carry);
                gt_d    = (op_q == CMP) && gtFlag;
                eq_d    = (op_q == CMP) && eq_acc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
        wren_d = (state_d == STEP) && (op_d != CMP);
        fclr_d = (state_d == CLR);
    end

    always_ff @(posedge Clk or posedge Res) begin
        if (Res) begin
            state_q  <= IDLE;
            op_q     <= ADD;
            len_q    <= '0;
            idx_q    <= '0;
            eq_acc_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wren_q   <= 1'b0;
            fclr_q   <= 1'b0;
            cout_q   <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            eq_acc_q <= eq_acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            wren_q   <= wren_d;
            fclr_q   <= fclr_d;
            cout_q   <= cout_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
        end
    end

    // Carry-in must follow Flags within the same step, so it cannot be registered.
    assign CinOut = (state_q == STEP) && (op_q != CMP) &&
                    ((idx_q == '0) ? (op_q == SUB) : ((op_q == SHL) ? SCarry : Carry));

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Err      = err_q;
    assign ByteIdx  = idx_q;
    assign AluOp    = op_q;
    assign WrEn     = wren_q;
    assign FlagClr  = fclr_q;
    assign CarryOut = cout_q;
    assign GtOut    = gt_q;
    assign EqOut    = eq_q;

endmodule
